// File: rtl/gp_wr_arbiter.sv
// Round-robin arbiter feeding one GP register-bank write port (address setup, then write strobe).
// Latency: request sampled in IDLE -> SETUP next cycle -> wren + s_ready the cycle after; 3 cycles per write.
// Backpressure: losers hold s_valid until their s_ready pulse; no request is dropped, no preemption.
module gp_wr_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    s_valid,
    input  logic [N_REQ*AW-1:0] s_addr,
    input  logic [N_REQ*DW-1:0] s_data,
    output logic [N_REQ-1:0]    s_ready,
    output logic [AW-1:0]       addr,
    output logic [DW-1:0]       data,
    output logic                wren,
    output logic                busy,
    output logic [1:0]          grant_id,
    output logic [15:0]         wr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [1:0]  grant_q;
    logic [1:0]  last_q;
    logic [15:0] wr_cnt_q;

    // Requests widened to 4 bits so a 2-bit candidate index is always in range.
    logic [3:0]  vld_pad;
    logic [1:0]  cand;
    logic        win_vld;
    logic [1:0]  win_idx;

    assign vld_pad = 4'(s_valid);

    // Round-robin pick: search starts one past the last grant, first requester found wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = 2'((int'(last_q) + k) % N_REQ);
            if (!win_vld && vld_pad[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state: arbitration only happens in IDLE; SETUP and WRITE always advance.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (win_vld) state_d = ST_SETUP;
            ST_SETUP: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat is latched at grant so later requester changes cannot disturb the write; counter bumps on the strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            data_q   <= '0;
            grant_q  <= 2'd0;
            last_q   <= 2'(N_REQ - 1);
            wr_cnt_q <= 16'd0;
        end else begin
            if (state_q == ST_IDLE && win_vld) begin
                addr_q  <= s_addr[int'(win_idx)*AW +: AW];
                data_q  <= s_data[int'(win_idx)*DW +: DW];
                grant_q <= win_idx;
                last_q  <= win_idx;
            end
            if (state_q == ST_WRITE) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    // Completion pulse goes only to the granted requester, only during the strobe cycle.
    always_comb begin
        s_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s_ready[i] = (state_q == ST_WRITE) && (grant_q == 2'(i));
        end
    end

    assign wren     = (state_q == ST_WRITE);
    assign busy     = (state_q != ST_IDLE);
    assign addr     = addr_q;
    assign data     = data_q;
    assign grant_id = grant_q;
    assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_gp_wr_arbiter.sv
// Bench for gp_wr_arbiter: requester agents, a timeline reference model and literal spot checks.
// Each step: model advances at the rising edge, agents respond 1 time unit later, outputs compared at the falling edge.
// Agents hold s_valid until s_ready, then drop it or present a fresh beat.
module tb_gp_wr_arbiter;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  s_valid;
    logic [95:0] s_addr, s_data;
    logic [2:0]  s_ready;
    logic [31:0] addr, data;
    logic        wren, busy;
    logic [1:0]  grant_id;
    logic [15:0] wr_cnt;

    always #5 clk = ~clk;

    gp_wr_arbiter #(.N_REQ(3), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_addr(s_addr), .s_data(s_data), .s_ready(s_ready),
        .addr(addr), .data(data), .wren(wren), .busy(busy),
        .grant_id(grant_id), .wr_cnt(wr_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: m_age counts cycles since the grant edge (0 = idle, 1 = address setup, 2 = strobe).
    int          m_age, m_gid, m_last;
    logic [31:0] m_addr, m_data;
    logic [15:0] m_cnt;

    // Agent state and observation logs.
    logic [31:0] beat_addr [3];
    logic [31:0] beat_data [3];
    int          reload [3];
    int          stall [3];
    bit          rand_en;
    logic [2:0]  last_rdy;
    logic        prev_wren;
    int          log_cyc [$];
    logic [31:0] log_addr [$];
    logic [2:0]  log_rdy [$];
    int          base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_gid = 0; m_last = N - 1;
        m_addr = 32'h0; m_data = 32'h0; m_cnt = 16'h0;
        prev_wren = 1'b0;
        for (int i = 0; i < N; i++) stall[i] = 0;
    endtask

    task automatic model_update();
        if (m_age == 2) begin
            m_cnt = m_cnt + 16'd1;
            m_age = 0;
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (s_valid[c]) begin
                    m_gid  = c;
                    m_last = c;
                    m_addr = s_addr[c*32 +: 32];
                    m_data = s_data[c*32 +: 32];
                    m_age  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic set_beat(input int i, input logic [31:0] a, input logic [31:0] d);
        beat_addr[i] = a;
        beat_data[i] = d;
        s_addr[i*32 +: 32] = a;
        s_data[i*32 +: 32] = d;
        s_valid[i] = 1'b1;
    endtask

    task automatic agents();
        for (int i = 0; i < N; i++) begin
            if (last_rdy[i]) begin
                if (reload[i] > 0) begin
                    reload[i]--;
                    set_beat(i, beat_addr[i] + 32'd4, beat_data[i] + 32'd1);
                end else if (rand_en && $urandom_range(0, 1) == 1) begin
                    set_beat(i, $urandom, $urandom);
                end else begin
                    s_valid[i] = 1'b0;
                end
            end else if (rand_en && !s_valid[i] && $urandom_range(0, 3) == 0) begin
                set_beat(i, $urandom, $urandom);
            end
        end
    endtask

    task automatic compare();
        logic       e_wren;
        logic [2:0] e_rdy;
        e_wren = (m_age == 2);
        e_rdy  = e_wren ? 3'(1 << m_gid) : 3'b000;
        chk("wren", {31'b0, wren}, {31'b0, e_wren});
        chk("s_ready", {29'b0, s_ready}, {29'b0, e_rdy});
        chk("busy", {31'b0, busy}, {31'b0, (m_age != 0)});
        chk("addr", addr, m_addr);
        chk("data", data, m_data);
        chk("grant_id", {30'b0, grant_id}, 32'(m_gid));
        chk("wr_cnt", {16'b0, wr_cnt}, {16'b0, m_cnt});
        chk("wren_gap", {31'b0, wren & prev_wren}, 32'd0);
        for (int i = 0; i < N; i++) begin
            if (s_ready[i]) begin
                chk("sb_addr", addr, beat_addr[i]);
                chk("sb_data", data, beat_data[i]);
            end
            if (s_valid[i] && !s_ready[i]) stall[i]++;
            else stall[i] = 0;
            if (stall[i] == 3 * N + 3) chk("starve", 32'(stall[i]), 32'd0);
        end
        if (wren) begin
            log_cyc.push_back(cyc);
            log_addr.push_back(addr);
            log_rdy.push_back(s_ready);
        end
        prev_wren = wren;
        last_rdy  = s_ready;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst_n) model_update();
        #1;
        agents();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_addr.delete();
        log_rdy.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 3'b000;
        for (int i = 0; i < N; i++) reload[i] = 0;
        #1;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        s_valid = 3'b000; s_addr = '0; s_data = '0;
        rand_en = 1'b0; last_rdy = 3'b000;
        for (int i = 0; i < N; i++) begin
            reload[i] = 0; beat_addr[i] = 32'h0; beat_data[i] = 32'h0;
        end
        model_reset();
        step();
        step();
        chk("rst_addr", addr, 32'h0);
        chk("rst_wren", {31'b0, wren}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {29'b0, s_ready}, 32'd0);
        chk("rst_wr_cnt", {16'b0, wr_cnt}, 32'd0);
        rst_n = 1'b1;

        // Single write from requester 1.
        set_beat(1, 32'h0000_0C05, 32'h1234);
        step();
        chk("single_setup_addr", addr, 32'h0000_0C05);
        chk("single_setup_busy", {31'b0, busy}, 32'd1);
        chk("single_setup_wren", {31'b0, wren}, 32'd0);
        step();
        chk("single_wren", {31'b0, wren}, 32'd1);
        chk("single_ready", {29'b0, s_ready}, 32'b010);
        chk("single_data", data, 32'h1234);
        step();
        chk("single_cnt", {16'b0, wr_cnt}, 32'd1);
        chk("single_gid", {30'b0, grant_id}, 32'd1);
        chk("single_idle", {31'b0, busy}, 32'd0);

        // Contention from reset priority: strobes at +2, +5, +8 in order 0,1,2.
        do_reset();
        clear_log();
        base = cyc;
        set_beat(0, 32'h401, 32'hA1);
        set_beat(1, 32'h402, 32'hA2);
        set_beat(2, 32'h403, 32'hA3);
        repeat (9) step();
        chk("cont_count", 32'(log_addr.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < log_addr.size()) begin
                chk("cont_addr", log_addr[k], 32'h401 + 32'(k));
                chk("cont_ready", {29'b0, log_rdy[k]}, 32'(1 << k));
                chk("cont_cycle", 32'(log_cyc[k] - base), 32'(2 + 3 * k));
            end
        end

        // Fairness: requesters 0 and 2 both keep valid for three beats each.
        clear_log();
        reload[0] = 2; reload[2] = 2;
        set_beat(0, 32'h600, 32'h60);
        set_beat(2, 32'h620, 32'h62);
        repeat (20) step();
        chk("fair_count", 32'(log_rdy.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < log_rdy.size())
                chk("fair_order", {29'b0, log_rdy[k]}, (k % 2 == 0) ? 32'b001 : 32'b100);
        end

        // Latch-at-grant: requester 0 changes data and drops valid during setup.
        set_beat(0, 32'h500, 32'hAAAA);
        step();
        s_data[31:0] = 32'hBBBB;
        s_valid[0] = 1'b0;
        step();
        chk("latch_wren", {31'b0, wren}, 32'd1);
        chk("latch_data", data, 32'hAAAA);
        chk("latch_ready", {29'b0, s_ready}, 32'b001);
        step();

        // Reset during setup: outputs clear at once, then priority restarts at requester 0.
        set_beat(0, 32'h800, 32'h88);
        step();
        rst_n = 1'b0;
        #1;
        chk("rmid_wren", {31'b0, wren}, 32'd0);
        chk("rmid_ready", {29'b0, s_ready}, 32'd0);
        chk("rmid_addr", addr, 32'h0);
        chk("rmid_busy", {31'b0, busy}, 32'd0);
        model_reset();
        set_beat(1, 32'h810, 32'h81);
        step();
        step();
        rst_n = 1'b1;
        clear_log();
        repeat (7) step();
        chk("rmid_count", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() >= 2) begin
            chk("rmid_first_ready", {29'b0, log_rdy[0]}, 32'b001);
            chk("rmid_first_addr", log_addr[0], 32'h800);
            chk("rmid_second_ready", {29'b0, log_rdy[1]}, 32'b010);
        end

        // Random traffic, then drain.
        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        repeat (30) step();
        chk("drain_valid", {29'b0, s_valid}, 32'd0);

        // Counter wrap: preload near the top, then two writes from requester 2.
        force dut.wr_cnt_q = 16'hFFFE;
        #1;
        release dut.wr_cnt_q;
        m_cnt = 16'hFFFE;
        clear_log();
        reload[2] = 1;
        set_beat(2, 32'h700, 32'h77);
        repeat (9) step();
        chk("wrap_count", 32'(log_addr.size()), 32'd2);
        chk("wrap_cnt", {16'b0, wr_cnt}, 32'd0);
        chk("wrap_hold_addr", addr, 32'h704);
        chk("wrap_hold_data", data, 32'h78);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
